serial_add_ctrl: RTL and testbench

//   Bit-serial adder controller that drives the existing 1-bit full_adder stage.

---
 rtl/serial_add_ctrl.sv | 141 ++++++++++++++
 tb/tb_serial_add_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: feeds operands LSB-first to an external 1-bit full adder and
// collects SUM/CARRY_OUT into a result register. Optional OVF output under SERIAL_ADD_OVF_EN.
module serial_add_ctrl #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             START,
  input  logic [WIDTH-1:0] OP_A,
  input  logic [WIDTH-1:0] OP_B,
  input  logic             CIN,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] RESULT,
  output logic             COUT,
`ifdef SERIAL_ADD_OVF_EN
  output logic             OVF,
`endif
  output logic             FA_A,
  output logic             FA_B,
  output logic             FA_CIN,
  input  logic             FA_SUM,
  input  logic             FA_COUT
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               cout_q, cout_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
`ifdef SERIAL_ADD_OVF_EN
  logic               ovf_q, ovf_d;
`endif

  // State and datapath registers
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q  <= S_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      carry_q  <= 1'b0;
      res_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      carry_q  <= carry_d;
      res_q    <= res_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    carry_d  = carry_q;
    res_d    = res_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    cout_d   = cout_q;
`ifdef SERIAL_ADD_OVF_EN
    ovf_d    = ovf_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (START) begin
          state_d = S_RUN;
          a_sh_d  = OP_A;
          b_sh_d  = OP_B;
          carry_d = CIN;
          res_d   = '0;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        res_d   = WIDTH'({FA_SUM, res_q} >> 1);
        carry_d = FA_COUT;
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        cnt_d   = cnt_q + CNT_W'(1);
        // Last bit: publish the sum including the bit returning this cycle
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d  = S_DONE;
          result_d = WIDTH'({FA_SUM, res_q} >> 1);
          cout_d   = FA_COUT;
`ifdef SERIAL_ADD_OVF_EN
          ovf_d    = carry_q ^ FA_COUT;
`endif
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  assign BUSY   = busy_q;
  assign DONE   = done_q;
  assign RESULT = result_q;
  assign COUT   = cout_q;
`ifdef SERIAL_ADD_OVF_EN
  assign OVF    = ovf_q;
`endif

  // Adder drive is gated so the stage sees zeros outside RUN
  assign FA_A   = (state_q == S_RUN) & a_sh_q[0];
  assign FA_B   = (state_q == S_RUN) & b_sh_q[0];
  assign FA_CIN = (state_q == S_RUN) & carry_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: behavioural transaction model checked every cycle, plus directed
// literal cases, an exhaustive 4-bit sweep and randomized START/RESET traffic.
module tb_serial_add_ctrl;
  localparam int unsigned W = 4;

  logic         CLK = 1'b0;
  logic         RESET_N, START, CIN;
  logic [W-1:0] OP_A, OP_B;
  logic         BUSY, DONE, COUT;
  logic [W-1:0] RESULT;
  logic         FA_A, FA_B, FA_CIN, FA_SUM, FA_COUT;
`ifdef SERIAL_ADD_OVF_EN
  logic         OVF;
`endif

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  bit chk_en = 1'b0;

  always #5 CLK = ~CLK;

  // The full_adder stage the controller talks to
  assign FA_SUM  = FA_A ^ FA_B ^ FA_CIN;
  assign FA_COUT = (FA_A & FA_B) | (FA_CIN & (FA_A ^ FA_B));

  serial_add_ctrl #(.WIDTH(W)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .START(START), .OP_A(OP_A), .OP_B(OP_B), .CIN(CIN),
    .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT), .COUT(COUT),
`ifdef SERIAL_ADD_OVF_EN
    .OVF(OVF),
`endif
    .FA_A(FA_A), .FA_B(FA_B), .FA_CIN(FA_CIN), .FA_SUM(FA_SUM), .FA_COUT(FA_COUT)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: age = cycles since acceptance (-1 when idle)
  int age = -1;
  int m_a = 0, m_b = 0, m_c = 0;
  int m_res = 0, m_cout = 0, m_ovf = 0;
  int m_sum;

  always @(posedge CLK) begin
    if (!RESET_N) begin
      age = -1; m_res = 0; m_cout = 0; m_ovf = 0;
    end else if (age < 0) begin
      if (START) begin
        age = 0; m_a = int'(OP_A); m_b = int'(OP_B); m_c = int'(CIN);
      end
    end else if (age == W) begin
      age = -1;
    end else begin
      age++;
      if (age == W) begin
        m_sum  = m_a + m_b + m_c;
        m_res  = m_sum % (1 << W);
        m_cout = (m_sum >> W) & 1;
        m_ovf  = ((((m_a % (1 << (W-1))) + (m_b % (1 << (W-1))) + m_c) >> (W-1)) & 1) ^ m_cout;
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge CLK) begin
    if (chk_en) begin
      bit run;
      int e_a, e_b, e_c;
      run = (age >= 0) && (age < W);
      e_a = run ? ((m_a >> age) & 1) : 0;
      e_b = run ? ((m_b >> age) & 1) : 0;
      e_c = run ? ((((m_a % (1 << age)) + (m_b % (1 << age)) + m_c) >> age) & 1) : 0;
      chk("busy", 32'(BUSY), 32'(age >= 0));
      chk("done", 32'(DONE), 32'(age == W));
      chk("result", 32'(RESULT), 32'(m_res));
      chk("cout", 32'(COUT), 32'(m_cout));
      chk("fa_a", 32'(FA_A), 32'(e_a));
      chk("fa_b", 32'(FA_B), 32'(e_b));
      chk("fa_cin", 32'(FA_CIN), 32'(e_c));
`ifdef SERIAL_ADD_OVF_EN
      chk("ovf", 32'(OVF), 32'(m_ovf));
`endif
      if (DONE === 1'b1) done_cnt++;
    end
  end

  // Issue one op at the current negedge (IDLE assumed) and wait for its DONE pulse
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                       input int exp_sum, input bit chk_lat);
    int n;
    OP_A = a; OP_B = b; CIN = c; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    n = 1;
    while (DONE !== 1'b1 && n < 20) begin
      @(negedge CLK);
      n++;
    end
    chk("done_seen", 32'(DONE), 32'd1);
    if (chk_lat) chk("latency", 32'(n), 32'(W + 1));
    chk("sum", 32'({COUT, RESULT}), 32'(exp_sum));
    @(negedge CLK);
  endtask

  initial begin
    int dc0;
    RESET_N = 1'b0; START = 1'b0; OP_A = '0; OP_B = '0; CIN = 1'b0;
    repeat (2) @(negedge CLK);
    chk_en = 1'b1;
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_done", 32'(DONE), 32'd0);
    chk("rst_result", 32'(RESULT), 32'h0);
    chk("rst_cout", 32'(COUT), 32'd0);
    chk("rst_fa", 32'({FA_A, FA_B, FA_CIN}), 32'd0);
    RESET_N = 1'b1;

    do_op(4'h3, 4'h5, 1'b0, 32'h08, 1'b1);
    chk("r35", 32'(RESULT), 32'h8);
`ifdef SERIAL_ADD_OVF_EN
    chk("ovf35", 32'(OVF), 32'd1);
`endif
    do_op(4'hF, 4'h1, 1'b1, 32'h11, 1'b1);
    chk("rF1_cout", 32'(COUT), 32'd1);
`ifdef SERIAL_ADD_OVF_EN
    chk("ovfF1", 32'(OVF), 32'd0);
`endif

    // START while busy must be ignored
    dc0 = done_cnt;
    OP_A = 4'h3; OP_B = 4'h5; CIN = 1'b0; START = 1'b1;
    @(negedge CLK); START = 1'b0;
    @(negedge CLK);
    OP_A = 4'hF; OP_B = 4'hF; START = 1'b1;
    @(negedge CLK); START = 1'b0;
    repeat (10) @(negedge CLK);
    chk("busy_ign_dones", 32'(done_cnt - dc0), 32'd1);
    chk("busy_ign_result", 32'({COUT, RESULT}), 32'h08);

    // Reset mid-operation aborts without a DONE pulse
    dc0 = done_cnt;
    OP_A = 4'h7; OP_B = 4'h7; CIN = 1'b0; START = 1'b1;
    @(negedge CLK); START = 1'b0;
    @(negedge CLK); RESET_N = 1'b0;
    repeat (2) @(negedge CLK);
    chk("abort_busy", 32'(BUSY), 32'd0);
    chk("abort_result", 32'({COUT, RESULT}), 32'h0);
    RESET_N = 1'b1;
    repeat (8) @(negedge CLK);
    chk("abort_no_done", 32'(done_cnt - dc0), 32'd0);
    do_op(4'h2, 4'h3, 1'b0, 32'h05, 1'b1);

    // Exhaustive back-to-back sweep
    dc0 = done_cnt;
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int c = 0; c < 2; c++)
          do_op(W'(a), W'(b), 1'(c), a + b + c, 1'b0);
    chk("sweep_dones", 32'(done_cnt - dc0), 32'd512);

    // Random START pulses, operands and occasional resets
    repeat (3000) begin
      RESET_N = ($urandom_range(199) != 0);
      START   = ($urandom_range(2) == 0);
      OP_A    = W'($urandom);
      OP_B    = W'($urandom);
      CIN     = 1'($urandom);
      @(negedge CLK);
    end
    RESET_N = 1'b1; START = 1'b0;
    repeat (10) @(negedge CLK);
    chk_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
